// File: rtl/trivium_pkg.sv
// Shared types, widths and tap positions for the Trivium keystream generator.
// Bit n-1 of a 288-bit state vector holds Trivium register bit s_n.
package trivium_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int KEY_W          = 32'd80;
    localparam int IV_W           = 32'd80;
    localparam int STATE_W        = 32'd288;
    localparam int DEFAULT_WARMUP = 32'd1152;
    localparam int IV_POS         = 32'd93;

    localparam int T_S66  = 32'd65;
    localparam int T_S69  = 32'd68;
    localparam int T_S91  = 32'd90;
    localparam int T_S92  = 32'd91;
    localparam int T_S93  = 32'd92;
    localparam int T_S162 = 32'd161;
    localparam int T_S171 = 32'd170;
    localparam int T_S175 = 32'd174;
    localparam int T_S176 = 32'd175;
    localparam int T_S177 = 32'd176;
    localparam int T_S243 = 32'd242;
    localparam int T_S264 = 32'd263;
    localparam int T_S286 = 32'd285;
    localparam int T_S287 = 32'd286;
    localparam int T_S288 = 32'd287;

    // Initial state: key into s1..s80, IV into s94..s173, s286..s288 set.
    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        logic [STATE_W-1:0] st;
        st                     = {STATE_W{1'b0}};
        st[KEY_W-1:0]          = key;
        st[IV_POS +: IV_W]     = iv;
        st[STATE_W-1 -: 3]     = 3'b111;
        return st;
    endfunction

endpackage

// File: rtl/trivium_step.sv
// One combinational Trivium step: produces the keystream bit z and the
// advanced 288-bit state.
module trivium_step
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] state_cur,
    output logic [STATE_W-1:0] state_nxt,
    output logic               z
);

    logic t1_s;
    logic t2_s;
    logic t3_s;
    logic n1_s;
    logic n2_s;
    logic n3_s;

    assign t1_s = state_cur[T_S66]  ^ state_cur[T_S93];
    assign t2_s = state_cur[T_S162] ^ state_cur[T_S177];
    assign t3_s = state_cur[T_S243] ^ state_cur[T_S288];
    assign z    = t1_s ^ t2_s ^ t3_s;

    assign n1_s = t1_s ^ (state_cur[T_S91]  & state_cur[T_S92])  ^ state_cur[T_S171];
    assign n2_s = t2_s ^ (state_cur[T_S175] & state_cur[T_S176]) ^ state_cur[T_S264];
    assign n3_s = t3_s ^ (state_cur[T_S286] & state_cur[T_S287]) ^ state_cur[T_S69];

    // Each of the three registers shifts by one; the feedback enters at its head.
    assign state_nxt = {state_cur[STATE_W-2:T_S177+1], n2_s,
                        state_cur[T_S177-1:T_S93+1],   n1_s,
                        state_cur[T_S93-1:0],          n3_s};

endmodule

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator with warm-up, block accumulator and valid/ready output.
// Define TRIVIUM_STREAM_GEN_XOR_EN to add data_i and emit keystream XOR data_i.
module trivium_stream_gen
    import trivium_pkg::*;
#(
    parameter int BLOCK_WIDTH    = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int WARMUP_STEPS   = DEFAULT_WARMUP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KEY_W-1:0]       key,
    input  logic [IV_W-1:0]        iv,
    output logic                   busy,
    output logic                   block_valid,
    input  logic                   block_ready,
`ifdef TRIVIUM_STREAM_GEN_XOR_EN
    input  logic [BLOCK_WIDTH-1:0] data_i,
`endif
    output logic [BLOCK_WIDTH-1:0] block_o
);

    localparam int WARM_CLKS = WARMUP_STEPS / BITS_PER_CYCLE;
    localparam int BEATS     = BLOCK_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W     = $clog2(WARM_CLKS + 2);
    localparam int FILL_W    = $clog2(BEATS + 2);

    state_t                    fsm_r;
    logic [STATE_W-1:0]        cipher_r;
    logic [STATE_W-1:0]        chain_s [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] z_s;
    logic [BLOCK_WIDTH-1:0]    acc_r;
    logic [BLOCK_WIDTH-1:0]    acc_nxt_s;
    logic [BLOCK_WIDTH-1:0]    block_r;
    logic [CNT_W-1:0]          warm_cnt_r;
    logic [FILL_W-1:0]         fill_r;
    logic                      valid_r;
    logic                      busy_r;
    logic                      full_s;
    logic                      advance_s;

    assign chain_s[0] = cipher_r;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        trivium_step u_step (
            .state_cur (chain_s[g]),
            .state_nxt (chain_s[g+1]),
            .z         (z_s[g])
        );
    end

    // Accumulator shifts right so the earliest step ends up at bit 0.
    always_comb begin
        acc_nxt_s = acc_r >> BITS_PER_CYCLE;
        acc_nxt_s[BLOCK_WIDTH-1 -: BITS_PER_CYCLE] = z_s;
    end

    // Cipher advances unless a full block is waiting on an unaccepted output.
    always_comb begin
        full_s    = (fill_r == FILL_W'(BEATS));
        advance_s = !full_s || !valid_r || block_ready;
    end

    // Control FSM, cipher state, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r      <= IDLE;
            cipher_r   <= {STATE_W{1'b0}};
            acc_r      <= {BLOCK_WIDTH{1'b0}};
            block_r    <= {BLOCK_WIDTH{1'b0}};
            warm_cnt_r <= {CNT_W{1'b0}};
            fill_r     <= {FILL_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else if (start) begin
            fsm_r      <= WARMUP;
            cipher_r   <= load_state(key, iv);
            acc_r      <= {BLOCK_WIDTH{1'b0}};
            warm_cnt_r <= {CNT_W{1'b0}};
            fill_r     <= {FILL_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            case (fsm_r)
                IDLE: begin
                    valid_r <= 1'b0;
                end
                WARMUP: begin
                    cipher_r <= chain_s[BITS_PER_CYCLE];
                    if (warm_cnt_r == CNT_W'(WARM_CLKS - 1)) begin
                        fsm_r      <= RUN;
                        warm_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        warm_cnt_r <= warm_cnt_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (advance_s) begin
                        cipher_r <= chain_s[BITS_PER_CYCLE];
                        acc_r    <= acc_nxt_s;
                        if (full_s) begin
                            // Hand over the block and start the next one this same cycle.
                            block_r <= acc_r;
                            valid_r <= 1'b1;
                            fill_r  <= FILL_W'(1);
                        end else begin
                            fill_r  <= fill_r + FILL_W'(1);
                            valid_r <= valid_r && !block_ready;
                        end
                    end
                end
                default: begin
                    fsm_r   <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign block_valid = valid_r;
`ifdef TRIVIUM_STREAM_GEN_XOR_EN
    assign block_o     = block_r ^ data_i;
`else
    assign block_o     = block_r;
`endif

endmodule

// File: tb/tb_trivium_stream_gen.sv
// Bench for trivium_stream_gen: BPC=1 and BPC=8 instances against a bit-level
// Trivium model, covering latency, back-pressure, restart and reset.
module tb_trivium_stream_gen;

    localparam int BW   = 64;
    localparam int NBLK = 256;
    localparam int LAT1 = 1 + 1152 + 64;
    localparam int LAT8 = 1 + 1152 / 8 + 64 / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready1;
    logic          ready8;
    logic [79:0]   key;
    logic [79:0]   iv;
    logic          busy1;
    logic          busy8;
    logic          valid1;
    logic          valid8;
    logic [BW-1:0] blk1;
    logic [BW-1:0] blk8;
    logic [BW-1:0] mask;

    logic [BW-1:0] exp_blk [0:NBLK-1];
    bit            ks [$];
    int            n_pass;
    int            n_total;
    int            cyc;
    bit            running;
    int            idx1;
    int            idx8;

    always #5 clk = ~clk;

    trivium_stream_gen #(.BLOCK_WIDTH(BW), .BITS_PER_CYCLE(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .iv          (iv),
        .busy        (busy1),
        .block_valid (valid1),
        .block_ready (ready1),
`ifdef TRIVIUM_STREAM_GEN_XOR_EN
        .data_i      (mask),
`endif
        .block_o     (blk1)
    );

    trivium_stream_gen #(.BLOCK_WIDTH(BW), .BITS_PER_CYCLE(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .iv          (iv),
        .busy        (busy8),
        .block_valid (valid8),
        .block_ready (ready8),
`ifdef TRIVIUM_STREAM_GEN_XOR_EN
        .data_i      (mask),
`endif
        .block_o     (blk8)
    );

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Reference Trivium on a 1-based bit array, straight from the cipher definition.
    task automatic run_model(input logic [79:0] k, input logic [79:0] v,
                             input int warm, input int nbits);
        bit s [1:288];
        bit t1, t2, t3, z;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            s[1 + i]  = k[i];
            s[94 + i] = v[i];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        ks.delete();
        for (int n = 0; n < warm + nbits; n++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i > 1; i--) s[i] = s[i-1];
            s[1] = t3; s[94] = t1; s[178] = t2;
            if (n >= warm) ks.push_back(z);
        end
    endtask

    task automatic build_blocks(input logic [79:0] k, input logic [79:0] v);
        run_model(k, v, 1152, NBLK * BW);
        for (int b = 0; b < NBLK; b++)
            for (int j = 0; j < BW; j++)
                exp_blk[b][j] = ks[b * BW + j];
    endtask

    task automatic pulse_start(input logic [79:0] k, input logic [79:0] v);
        key   = k;
        iv    = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_stream(input string nm, input int lat, input int idx,
                                input logic v, input logic [BW-1:0] b);
        if (cyc < lat)       check({nm, "_valid_early"}, BW'(v), BW'(0));
        else if (cyc == lat) check({nm, "_valid_first"}, BW'(v), BW'(1));
        if (v) begin
            if (idx < NBLK) check({nm, "_block"}, b, exp_blk[idx] ^ mask);
            else            check({nm, "_block_index"}, BW'(idx), BW'(NBLK - 1));
        end
    endtask

    // Run tracker: cycles since start and blocks consumed per instance.
    always @(posedge clk) begin
        if (rst) begin
            running <= 1'b0; cyc <= 0; idx1 <= 0; idx8 <= 0;
        end else if (start) begin
            running <= 1'b1; cyc <= 0; idx1 <= 0; idx8 <= 0;
        end else begin
            cyc <= cyc + 1;
            if (valid1 && ready1) idx1 <= idx1 + 1;
            if (valid8 && ready8) idx8 <= idx8 + 1;
        end
    end

    // Compare process: every cycle outside reset/start cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !start) begin
                if (!running) begin
                    check("idle_busy1",  BW'(busy1),  BW'(0));
                    check("idle_busy8",  BW'(busy8),  BW'(0));
                    check("idle_valid1", BW'(valid1), BW'(0));
                    check("idle_valid8", BW'(valid8), BW'(0));
                    check("idle_block1", blk1, mask);
                    check("idle_block8", blk8, mask);
                end else begin
                    check("busy1", BW'(busy1), BW'(1));
                    check("busy8", BW'(busy8), BW'(1));
                    check_stream("bpc1", LAT1, idx1, valid1, blk1);
                    check_stream("bpc8", LAT8, idx8, valid8, blk8);
                end
            end
        end
    end

    initial begin
        int            n;
        logic [79:0]   k;
        logic [79:0]   v;
        rst = 1'b1; start = 1'b0; ready1 = 1'b1; ready8 = 1'b1;
        key = 80'h0; iv = 80'h0;
`ifdef TRIVIUM_STREAM_GEN_XOR_EN
        mask = {BW{1'b1}};
`else
        mask = {BW{1'b0}};
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-derived first steps from the loaded state (no warm-up).
        run_model(80'h0, 80'h0, 0, 4);
        check("pin_zero_first4", BW'({ks[3], ks[2], ks[1], ks[0]}), BW'(4'b0111));
        k = 80'h0; k[65] = 1'b1;
        run_model(k, 80'h0, 0, 1);
        check("pin_key_s66", BW'(ks[0]), BW'(0));
        v = 80'h0; v[68] = 1'b1;
        run_model(80'h0, v, 0, 1);
        check("pin_iv_s162", BW'(ks[0]), BW'(0));

        repeat (2) @(posedge clk);
        #1;

        // key=0, iv=0; hold off the BPC=1 consumer for 500 clocks after first valid.
        build_blocks(80'h0, 80'h0);
        ready1 = 1'b0;
        pulse_start(80'h0, 80'h0);
        n = 0;
        while (!valid1 && n < LAT1 + 20) begin
            @(posedge clk); #1; n++;
        end
        check("first_valid_timeout", BW'(valid1), BW'(1));
        repeat (500) @(posedge clk);
        #1 ready1 = 1'b1;
        n = 0;
        while (idx1 < 5 && n < 6 * BW) begin
            @(posedge clk); #1; n++;
        end
        check("stall_resume_timeout", BW'(idx1 >= 5), BW'(1));

        // Restart mid-RUN with a new key.
        build_blocks(80'h1, 80'h0);
        pulse_start(80'h1, 80'h0);
        n = 0;
        while (idx1 < 3 && n < LAT1 + 4 * BW) begin
            @(posedge clk); #1; n++;
        end
        check("restart_timeout", BW'(idx1 >= 3), BW'(1));

        // rst together with start during warm-up: reset wins, nothing is produced.
        build_blocks(80'h0, 80'h0);
        pulse_start(80'h0, 80'h0);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy",  BW'(busy1),  BW'(0));
        check("rst_start_valid", BW'(valid1), BW'(0));
        check("rst_start_block", blk1, mask);
        repeat (LAT1 + 100) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
